ram_arbiter: RTL and testbench

- Shares the single data-RAM port between the minicpu data port (master 0) and a DMA/debug loader (master 1).
- Same-cycle grant, so the single-cycle CPU still sees combinational read data.
- DMA bursts, a bounded burst length and a starvation counter are sequenced by a small FSM.
- A stall output freezes the CPU PC whenever the CPU is refused the port.

---
 rtl/ram_arbiter_pkg.sv | 24 ++
 rtl/ram_arbiter_grant.sv | 31 +++
 rtl/ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter: FSM state encodings,
// grant encodings and active-low strobe levels.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_BURST = 2'b01,
        ARB_COOL  = 2'b10
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_DMA  = 2'b10
    } arb_gnt_e;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    function automatic logic is_req(input logic rd_, input logic wr_);
        return (rd_ == ENABLE_) || (wr_ == ENABLE_);
    endfunction

endpackage

// File: rtl/ram_arbiter_grant.sv
// Purely combinational priority decode choosing which master owns the RAM
// port this cycle, from live requests and registered arbiter state.
module ram_arbiter_grant
    import ram_arbiter_pkg::*;
(
    input  logic       rst_,
    input  arb_state_e state,
    input  logic       creq,
    input  logic       dreq,
    input  logic       starve_full,
    output arb_gnt_e   grant
);

    always_comb begin
        grant = GNT_NONE;
        if (!rst_) begin
            grant = GNT_NONE;
        end else if (state == ARB_BURST && dreq) begin
            grant = GNT_DMA;
        end else if (state == ARB_COOL && creq) begin
            grant = GNT_CPU;
        end else if (starve_full && dreq) begin
            grant = GNT_DMA;
        end else if (creq) begin
            grant = GNT_CPU;
        end else if (dreq) begin
            grant = GNT_DMA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single data-RAM port between the CPU data port and the DMA/debug
// loader, with same-cycle grant, bounded DMA bursts and starvation forcing.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int MAX_BURST  = 4,
    parameter int STARVE_LIM = 6
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              cpu_rd_,
    input  logic              cpu_wr_,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_d_in,
    output logic              cpu_stall,
    input  logic              dma_rd_,
    input  logic              dma_wr_,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_d_in,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d_in,
    output logic              ram_rd_,
    output logic              ram_wr_,
    input  logic [DATA_W-1:0] ram_d_out,
    output logic              proto_err
);

    localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int SCNT_W = $clog2(STARVE_LIM + 1);
    localparam logic BURST_EN = (MAX_BURST > 1);
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);
    localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIM);

    arb_state_e        state_q, state_d;
    logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [SCNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic     creq, dreq;
    arb_gnt_e grant;
    logic     cpu_gnt_w, dma_gnt_w;
    logic     sel_rd_, sel_wr_;

    // Read data is routed to both masters outside this block.
    logic unused_ram_d_out;
    assign unused_ram_d_out = ^ram_d_out;

    assign creq = is_req(cpu_rd_, cpu_wr_);
    assign dreq = is_req(dma_rd_, dma_wr_);

    ram_arbiter_grant u_grant (
        .rst_        (rst_),
        .state       (state_q),
        .creq        (creq),
        .dreq        (dreq),
        .starve_full (starve_cnt_q == STARVE_MAX),
        .grant       (grant)
    );

    assign cpu_gnt_w = (grant == GNT_CPU);
    assign dma_gnt_w = (grant == GNT_DMA);

    always_comb begin
        ram_addr  = cpu_addr;
        ram_d_in  = cpu_d_in;
        sel_rd_   = cpu_rd_;
        sel_wr_   = cpu_wr_;
        if (dma_gnt_w) begin
            ram_addr = dma_addr;
            ram_d_in = dma_d_in;
            sel_rd_  = dma_rd_;
            sel_wr_  = dma_wr_;
        end
    end

    // A granted master asserting both strobes is resolved as a write.
    always_comb begin
        ram_rd_   = DISABLE_;
        ram_wr_   = DISABLE_;
        proto_err = 1'b0;
        if (grant != GNT_NONE) begin
            if (sel_rd_ == ENABLE_ && sel_wr_ == ENABLE_) begin
                ram_wr_   = ENABLE_;
                proto_err = 1'b1;
            end else begin
                ram_rd_ = sel_rd_;
                ram_wr_ = sel_wr_;
            end
        end
    end

    assign cpu_stall = creq & ~cpu_gnt_w;
    assign dma_gnt   = dma_gnt_w;

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (dma_gnt_w && dma_lock && BURST_EN) begin
                    state_d     = ARB_BURST;
                    burst_cnt_d = BCNT_W'(1);
                end
            end
            ARB_BURST: begin
                if (dma_gnt_w && burst_cnt_q == BURST_LAST) begin
                    state_d     = ARB_COOL;
                    burst_cnt_d = '0;
                end else if (dma_gnt_w && dma_lock) begin
                    burst_cnt_d = burst_cnt_q + BCNT_W'(1);
                end else begin
                    state_d     = ARB_IDLE;
                    burst_cnt_d = '0;
                end
            end
            ARB_COOL: begin
                state_d     = ARB_IDLE;
                burst_cnt_d = '0;
            end
            default: begin
                state_d     = ARB_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        starve_cnt_d = '0;
        if (dreq && !dma_gnt_w) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q
                                                        : starve_cnt_q + SCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= ARB_IDLE;
            burst_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM; expectations are
// hand-computed constants per cycle.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic       clk;
    logic       rst_;
    logic       cpu_rd_, cpu_wr_;
    logic [7:0] cpu_addr, cpu_d_in;
    logic       cpu_stall;
    logic       dma_rd_, dma_wr_;
    logic [7:0] dma_addr, dma_d_in;
    logic       dma_lock;
    logic       dma_gnt;
    logic [7:0] ram_addr, ram_d_in, ram_d_out;
    logic       ram_rd_, ram_wr_;
    logic       proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [256];

    ram_arbiter dut (
        .clk       (clk),
        .rst_      (rst_),
        .cpu_rd_   (cpu_rd_),
        .cpu_wr_   (cpu_wr_),
        .cpu_addr  (cpu_addr),
        .cpu_d_in  (cpu_d_in),
        .cpu_stall (cpu_stall),
        .dma_rd_   (dma_rd_),
        .dma_wr_   (dma_wr_),
        .dma_addr  (dma_addr),
        .dma_d_in  (dma_d_in),
        .dma_lock  (dma_lock),
        .dma_gnt   (dma_gnt),
        .ram_addr  (ram_addr),
        .ram_d_in  (ram_d_in),
        .ram_rd_   (ram_rd_),
        .ram_wr_   (ram_wr_),
        .ram_d_out (ram_d_out),
        .proto_err (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!ram_wr_) mem[ram_addr] <= ram_d_in;
    end
    assign ram_d_out = mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cpu_set(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        cpu_rd_ = rd; cpu_wr_ = wr; cpu_addr = a; cpu_d_in = d;
    endtask

    task automatic dma_set(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input logic lock);
        dma_rd_ = rd; dma_wr_ = wr; dma_addr = a; dma_d_in = d; dma_lock = lock;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ = 1'b0;
        cpu_set(1, 0, 8'h00, 8'h00);
        dma_set(1, 0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ram_wr", 32'(ram_wr_), 32'd1);
        chk("rst_ram_rd", 32'(ram_rd_), 32'd1);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_proto", 32'(proto_err), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
        cpu_set(1, 1, 8'h00, 8'h00);
        dma_set(1, 1, 8'h00, 8'h00, 1'b0);
        rst_ = 1'b1;
        next_cyc();

        // CPU write then read-back
        cpu_set(1, 0, 8'h10, 8'hA5);
        @(negedge clk);
        chk("cpu_wr_strobe", 32'(ram_wr_), 32'd0);
        chk("cpu_wr_addr", 32'(ram_addr), 32'h10);
        chk("cpu_wr_stall", 32'(cpu_stall), 32'd0);
        next_cyc();
        cpu_set(0, 1, 8'h10, 8'h00);
        @(negedge clk);
        chk("cpu_rd_strobe", 32'(ram_rd_), 32'd0);
        chk("cpu_rd_wr_off", 32'(ram_wr_), 32'd1);
        chk("cpu_rd_addr", 32'(ram_addr), 32'h10);
        chk("cpu_rd_data", 32'(ram_d_out), 32'hA5);
        chk("cpu_rd_stall", 32'(cpu_stall), 32'd0);
        next_cyc();

        // Contention then starvation: DMA forced in on cycle 7
        cpu_set(0, 1, 8'h11, 8'h00);
        dma_set(0, 1, 8'h30, 8'h00, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("starve_gnt_c%0d", c), 32'(dma_gnt), 32'(c == 7));
            chk($sformatf("starve_stall_c%0d", c), 32'(cpu_stall), 32'(c == 7));
            chk($sformatf("starve_addr_c%0d", c), 32'(ram_addr), (c == 7) ? 32'h30 : 32'h11);
            next_cyc();
            chk($sformatf("starve_cnt_c%0d", c), 32'(dut.starve_cnt_q),
                (c <= 6) ? 32'(c) : ((c == 7) ? 32'd0 : 32'd1));
        end
        cpu_set(1, 1, 8'h00, 8'h00);
        dma_set(1, 1, 8'h00, 8'h00, 1'b0);
        next_cyc();
        chk("starve_clear", 32'(dut.starve_cnt_q), 32'd0);

        // Full burst entered through a starvation grant
        cpu_set(0, 1, 8'h12, 8'h00);
        dma_set(1, 0, 8'h40, 8'h5A, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("burst_state_c%0d", c), 32'(dut.state_q),
                (c <= 7 || c == 12) ? 32'(ARB_IDLE) :
                (c <= 10) ? 32'(ARB_BURST) : 32'(ARB_COOL));
            chk($sformatf("burst_gnt_c%0d", c), 32'(dma_gnt), 32'(c >= 7 && c <= 10));
            chk($sformatf("burst_stall_c%0d", c), 32'(cpu_stall), 32'(c >= 7 && c <= 10));
            if (c == 7) begin
                chk("burst_wr_strobe", 32'(ram_wr_), 32'd0);
                chk("burst_wr_addr", 32'(ram_addr), 32'h40);
            end
            next_cyc();
            if (c == 12) chk("burst_rewait", 32'(dut.starve_cnt_q), 32'd2);
        end
        chk("burst_mem", 32'(mem[8'h40]), 32'h5A);
        cpu_set(1, 1, 8'h00, 8'h00);
        dma_set(1, 1, 8'h00, 8'h00, 1'b0);
        next_cyc();

        // Burst abort by dropping the lock on the second granted cycle
        dma_set(0, 1, 8'h50, 8'h00, 1'b1);
        @(negedge clk);
        chk("abort_gnt1", 32'(dma_gnt), 32'd1);
        next_cyc();
        chk("abort_in_burst", 32'(dut.state_q), 32'(ARB_BURST));
        dma_set(0, 1, 8'h51, 8'h00, 1'b0);
        cpu_set(0, 1, 8'h13, 8'h00);
        @(negedge clk);
        chk("abort_gnt2", 32'(dma_gnt), 32'd1);
        chk("abort_stall2", 32'(cpu_stall), 32'd1);
        next_cyc();
        chk("abort_idle", 32'(dut.state_q), 32'(ARB_IDLE));
        @(negedge clk);
        chk("abort_cpu_gnt", 32'(dma_gnt), 32'd0);
        chk("abort_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("abort_cpu_addr", 32'(ram_addr), 32'h13);
        cpu_set(1, 1, 8'h00, 8'h00);
        dma_set(1, 1, 8'h00, 8'h00, 1'b0);
        next_cyc();

        // Reset pulse in the middle of a burst
        dma_set(1, 0, 8'h60, 8'h77, 1'b1);
        @(negedge clk);
        chk("rstb_gnt", 32'(dma_gnt), 32'd1);
        next_cyc();
        chk("rstb_in_burst", 32'(dut.state_q), 32'(ARB_BURST));
        @(negedge clk);
        #2 rst_ = 1'b0;
        #1;
        chk("rstb_wr_off", 32'(ram_wr_), 32'd1);
        chk("rstb_gnt_off", 32'(dma_gnt), 32'd0);
        chk("rstb_state", 32'(dut.state_q), 32'(ARB_IDLE));
        chk("rstb_cnt", 32'(dut.burst_cnt_q), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        chk("rstb_release_state", 32'(dut.state_q), 32'(ARB_IDLE));
        chk("rstb_release_gnt", 32'(dma_gnt), 32'd1);
        dma_set(1, 1, 8'h00, 8'h00, 1'b0);
        next_cyc();

        // Protocol error: both CPU strobes low
        cpu_set(0, 0, 8'h20, 8'h3C);
        @(negedge clk);
        chk("proto_wr", 32'(ram_wr_), 32'd0);
        chk("proto_rd", 32'(ram_rd_), 32'd1);
        chk("proto_err", 32'(proto_err), 32'd1);
        chk("proto_addr", 32'(ram_addr), 32'h20);
        next_cyc();
        cpu_set(1, 1, 8'h00, 8'h00);
        @(negedge clk);
        chk("proto_clear", 32'(proto_err), 32'd0);
        chk("proto_idle_wr", 32'(ram_wr_), 32'd1);
        chk("proto_mem", 32'(mem[8'h20]), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
